vga_timing_gen: RTL and testbench

//   640x480@60Hz VGA timing generator and pixel output stage; drives h_cnt/v_cnt to the scene blocks.

---
 rtl/vga_timing_gen_if.sv | 27 ++
 rtl/vga_timing_gen.sv | 102 ++++++++++
 tb/tb_vga_timing_gen.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Bus between the VGA timing generator and its neighbours.
// The scene side supplies pixel colour; the pin side consumes counts, strobes, syncs and RGB.
interface vga_timing_gen_if;
  logic [11:0] vga_data;
  logic [9:0]  h_cnt;
  logic [9:0]  v_cnt;
  logic        valid;
  logic        pix_en;
  logic        frame_start;
  logic        hsync;
  logic        vsync;
  logic [3:0]  vgaRed;
  logic [3:0]  vgaGreen;
  logic [3:0]  vgaBlue;

  modport master (
    input  vga_data,
    output h_cnt, v_cnt, valid, pix_en, frame_start,
    output hsync, vsync, vgaRed, vgaGreen, vgaBlue
  );

  modport slave (
    output vga_data,
    input  h_cnt, v_cnt, valid, pix_en, frame_start,
    input  hsync, vsync, vgaRed, vgaGreen, vgaBlue
  );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60Hz VGA timing generator with a registered pixel output stage.
// Pins lag the counts by one pixel; syncs and RGB stay mutually aligned.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_FP    = 16,
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BP    = 48,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_FP    = 10,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BP    = 33
) (
  input  logic clk,
  input  logic rst,
  vga_timing_gen_if.master bus
);
  localparam int unsigned H_TOTAL = H_DISP + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_DISP + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(CLK_DIV - 1);
  // pix_en is registered, so it is armed one divider step early (CLK_DIV >= 2)
  localparam logic [DIV_W-1:0] DIV_PRE = DIV_W'(CLK_DIV - 2);

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISP);
  localparam logic [9:0] V_VIS    = 10'(V_DISP);
  localparam logic [9:0] HS_START = 10'(H_DISP + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_DISP + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_DISP + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_DISP + V_FP + V_SYNC);

  logic [DIV_W-1:0] r_div;
  logic             r_pix_en;
  logic [9:0]       r_h_cnt;
  logic [9:0]       r_v_cnt;
  logic             r_frame_start;
  logic             r_hsync;
  logic             r_vsync;
  logic [11:0]      r_rgb;

  logic w_valid;
  logic w_hsync;
  logic w_vsync;
  logic w_h_wrap;
  logic w_v_wrap;

  always_comb begin
    w_valid  = (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
    w_hsync  = ~((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
    w_vsync  = ~((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
    w_h_wrap = (r_h_cnt == H_MAX);
    w_v_wrap = (r_v_cnt == V_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_div    <= '0;
      r_pix_en <= 1'b0;
    end else begin
      r_div    <= (r_div == DIV_MAX) ? '0 : r_div + 1'b1;
      r_pix_en <= (r_div == DIV_PRE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt       <= '0;
      r_v_cnt       <= '0;
      r_frame_start <= 1'b0;
      r_hsync       <= 1'b1;
      r_vsync       <= 1'b1;
      r_rgb         <= '0;
    end else begin
      r_frame_start <= r_pix_en && w_h_wrap && w_v_wrap;
      if (r_pix_en) begin
        r_rgb   <= w_valid ? bus.vga_data : '0;
        r_hsync <= w_hsync;
        r_vsync <= w_vsync;
        if (w_h_wrap) begin
          r_h_cnt <= '0;
          r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 10'd1;
        end else begin
          r_h_cnt <= r_h_cnt + 10'd1;
        end
      end
    end
  end

  assign bus.h_cnt       = r_h_cnt;
  assign bus.v_cnt       = r_v_cnt;
  assign bus.valid       = w_valid;
  assign bus.pix_en      = r_pix_en;
  assign bus.frame_start = r_frame_start;
  assign bus.hsync       = r_hsync;
  assign bus.vsync       = r_vsync;
  assign bus.vgaRed      = r_rgb[11:8];
  assign bus.vgaGreen    = r_rgb[7:4];
  assign bus.vgaBlue     = r_rgb[3:0];
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line timing and a shrunken
// instance for frame-level timing, both checked every clock against a closed-form model.
module tb_vga_timing_gen;
  localparam int unsigned CD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] vga_data;

  always #5 clk = ~clk;

  vga_timing_gen_if vif_f();
  vga_timing_gen_if vif_s();
  assign vif_f.vga_data = vga_data;
  assign vif_s.vga_data = vga_data;

  vga_timing_gen #(.CLK_DIV(CD)) u_full (
    .clk (clk),
    .rst (rst),
    .bus (vif_f)
  );

  vga_timing_gen #(
    .CLK_DIV(CD), .H_DISP(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_DISP(8), .V_FP(2), .V_SYNC(2), .V_BP(3)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (vif_s)
  );

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        valid;
    logic        pe;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [11:0] rgb;
  } obs_t;

  typedef struct {
    int unsigned n;
    logic        pe;
    logic [9:0]  h;
  } vec_t;

  int   n_checks = 0;
  int   n_errors = 0;
  int unsigned n = 0;
  obs_t q_f[$];
  obs_t q_s[$];

  bit run1 = 1'b1;
  int hs_first = -1;
  int hs_low   = 0;
  int wrap_n   = -1;
  int vs_first = -1;
  int vs_low   = 0;
  int fs_list[$];

  function automatic logic [11:0] g(int unsigned k);
    return ((k / 64) % 2 == 0) ? 12'hA5C : 12'((k * 29 + 273) % 4096);
  endfunction

  function automatic obs_t model(int unsigned k, int unsigned hd, int unsigned hf,
                                 int unsigned hsy, int unsigned hb, int unsigned vd,
                                 int unsigned vf, int unsigned vsy, int unsigned vb);
    obs_t o;
    int unsigned ht = hd + hf + hsy + hb;
    int unsigned vt = vd + vf + vsy + vb;
    int unsigned p  = k / CD;
    int unsigned hq, vq;
    o.h     = 10'(p % ht);
    o.v     = 10'((p / ht) % vt);
    o.valid = ((p % ht) < hd) && (((p / ht) % vt) < vd);
    o.pe    = ((k % CD) == CD - 1);
    o.fs    = ((k % CD) == 0) && (p > 0) && ((p % (ht * vt)) == 0);
    if (p == 0) begin
      o.hs  = 1'b1;
      o.vs  = 1'b1;
      o.rgb = 12'h000;
    end else begin
      hq    = (p - 1) % ht;
      vq    = ((p - 1) / ht) % vt;
      o.hs  = !(hq >= hd + hf && hq < hd + hf + hsy);
      o.vs  = !(vq >= vd + vf && vq < vd + vf + vsy);
      o.rgb = (hq < hd && vq < vd) ? g(CD * p - 1) : 12'h000;
    end
    return o;
  endfunction

  function automatic obs_t model_f(int unsigned k);
    return model(k, 640, 16, 96, 48, 480, 10, 2, 33);
  endfunction

  function automatic obs_t model_s(int unsigned k);
    return model(k, 16, 2, 4, 3, 8, 2, 2, 3);
  endfunction

  function automatic obs_t grab_f();
    obs_t o;
    o.h = vif_f.h_cnt; o.v = vif_f.v_cnt; o.valid = vif_f.valid; o.pe = vif_f.pix_en;
    o.fs = vif_f.frame_start; o.hs = vif_f.hsync; o.vs = vif_f.vsync;
    o.rgb = {vif_f.vgaRed, vif_f.vgaGreen, vif_f.vgaBlue};
    return o;
  endfunction

  function automatic obs_t grab_s();
    obs_t o;
    o.h = vif_s.h_cnt; o.v = vif_s.v_cnt; o.valid = vif_s.valid; o.pe = vif_s.pix_en;
    o.fs = vif_s.frame_start; o.hs = vif_s.hsync; o.vs = vif_s.vsync;
    o.rgb = {vif_s.vgaRed, vif_s.vgaGreen, vif_s.vgaBlue};
    return o;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input obs_t a, input obs_t e);
    chk({tag, ".h_cnt"},       32'(a.h),     32'(e.h));
    chk({tag, ".v_cnt"},       32'(a.v),     32'(e.v));
    chk({tag, ".valid"},       32'(a.valid), 32'(e.valid));
    chk({tag, ".pix_en"},      32'(a.pe),    32'(e.pe));
    chk({tag, ".frame_start"}, 32'(a.fs),    32'(e.fs));
    chk({tag, ".hsync"},       32'(a.hs),    32'(e.hs));
    chk({tag, ".vsync"},       32'(a.vs),    32'(e.vs));
    chk({tag, ".rgb"},         32'(a.rgb),   32'(e.rgb));
  endtask

  task automatic step();
    obs_t ef, es, af, as;
    @(posedge clk);
    n++;
    q_f.push_back(model_f(n));
    q_s.push_back(model_s(n));
    @(negedge clk);
    af = grab_f();
    as = grab_s();
    if (q_f.size() == 0 || q_s.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      ef = q_f.pop_front();
      es = q_s.pop_front();
      cmp($sformatf("full n=%0d", n), af, ef);
      cmp($sformatf("small n=%0d", n), as, es);
    end
    if (run1) begin
      if (!af.hs) begin
        if (hs_first < 0) hs_first = int'(n);
        if (n < 3200) hs_low++;
      end
      if (af.h == 10'd0 && af.v == 10'd1 && wrap_n < 0) wrap_n = int'(n);
      if (!as.vs) begin
        if (vs_first < 0) vs_first = int'(n);
        if (n < 1500) vs_low++;
      end
      if (as.fs) fs_list.push_back(int'(n));
    end
    vga_data = g(n);
  endtask

  task automatic release_rst();
    @(negedge clk);
    rst      = 1'b0;
    n        = 0;
    vga_data = g(0);
  endtask

  vec_t vecs[12];

  task automatic run_startup(input string tag);
    obs_t a;
    for (int i = 0; i < 12; i++) begin
      step();
      a = grab_f();
      chk($sformatf("%s tbl%0d.pix_en", tag, vecs[i].n), 32'(a.pe), 32'(vecs[i].pe));
      chk($sformatf("%s tbl%0d.h_cnt", tag, vecs[i].n),  32'(a.h),  32'(vecs[i].h));
      chk($sformatf("%s tbl%0d.v_cnt", tag, vecs[i].n),  32'(a.v),  32'd0);
    end
  endtask

  initial begin
    vecs = '{
      '{1, 1'b0, 10'd0}, '{2, 1'b0, 10'd0}, '{3, 1'b1, 10'd0}, '{4, 1'b0, 10'd1},
      '{5, 1'b0, 10'd1}, '{6, 1'b0, 10'd1}, '{7, 1'b1, 10'd1}, '{8, 1'b0, 10'd2},
      '{9, 1'b0, 10'd2}, '{10, 1'b0, 10'd2}, '{11, 1'b1, 10'd2}, '{12, 1'b0, 10'd3}
    };
    vga_data = g(0);
    rst      = 1'b1;
    repeat (3) @(negedge clk);
    cmp("reset_f", grab_f(), model_f(0));
    cmp("reset_s", grab_s(), model_s(0));

    release_rst();
    run_startup("start");
    while (n < 4401) step();

    chk("hsync_first_low_n", 32'(hs_first), 32'd2628);
    chk("hsync_low_clks",    32'(hs_low),   32'd384);
    chk("line_wrap_n",       32'(wrap_n),   32'd3200);
    chk("vsync_first_low_n", 32'(vs_first), 32'd1004);
    chk("vsync_low_clks",    32'(vs_low),   32'd200);
    chk("frame_start_count", 32'(fs_list.size()), 32'd2);
    if (fs_list.size() == 2) begin
      chk("frame_start_0_n", 32'(fs_list[0]), 32'd1500);
      chk("frame_start_1_n", 32'(fs_list[1]), 32'd3000);
    end
    chk("mid_h_before_rst", 32'(vif_f.h_cnt), 32'd300);
    chk("mid_v_before_rst", 32'(vif_f.v_cnt), 32'd1);

    run1 = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    cmp("async_rst_f", grab_f(), model_f(0));
    cmp("async_rst_s", grab_s(), model_s(0));
    repeat (2) @(negedge clk);
    cmp("held_rst_f", grab_f(), model_f(0));
    cmp("held_rst_s", grab_s(), model_s(0));

    release_rst();
    run_startup("restart");
    repeat (40) step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
